// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM write path.
//   SRAM_ADDR_W / SRAM_DATA_W : default SRAM word address / data widths
//   sram_wr_req_t             : one buffered write request {addr, data, be}
//   wr_state_t                : write-cycle sequencer states
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
        logic [1:0]             be;     // [1]=upper byte, [0]=lower byte
    } sram_wr_req_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } wr_state_t;

endpackage

// File: rtl/sram_write_ctrl_sync_fifo.sv
// sync_fifo: synchronous first-word-fall-through FIFO of write requests.
//   clk_i, rst_ni : clock, synchronous active-low reset (flushes the FIFO)
//   push_i        : write push_data_i when not full (ignored while full)
//   pop_i         : drop head_o when not empty
//   head_o        : oldest entry, valid whenever empty_o==0
//   count_o       : number of stored entries (0..DEPTH)
//   full_o/empty_o: status derived from registered count only
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import sram_pkg::*;
#(
    parameter type         ENTRY_T = sram_wr_req_t,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  ENTRY_T                 push_data_i,
    input  logic                   pop_i,
    output ENTRY_T                 head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    ENTRY_T        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl: buffers write requests and replays them as timed
// asynchronous-SRAM write cycles (SETUP, WE_CYCLES of PULSE, HOLD).
//   Clk, Reset          : clock, synchronous active-low reset
//   wr_valid/wr_ready   : request handshake; wr_addr/wr_data/wr_be payload
//   rd_active           : read path wants the bus; checked only between cycles
//   bus_owned           : this block drives the SRAM pins (top-level mux select)
//   SRAM_ADDR, Data_to_SRAM, data_drive, CE_N, WE_N, UB_N, LB_N : registered pins
//   fifo_count, idle    : buffer occupancy, nothing queued and sequencer idle
module sram_write_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = SRAM_ADDR_W,
    parameter int unsigned DATA_W     = SRAM_DATA_W,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WE_CYCLES  = 2
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [1:0]                  wr_be,
    input  logic                        rd_active,
    output logic                        bus_owned,
    output logic [ADDR_W-1:0]           SRAM_ADDR,
    output logic [DATA_W-1:0]           Data_to_SRAM,
    output logic                        data_drive,
    output logic                        CE_N,
    output logic                        WE_N,
    output logic                        UB_N,
    output logic                        LB_N,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        idle
);

    localparam int unsigned CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        be;
    } req_t;

    req_t                        push_req;
    req_t                        head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                        launch;
    logic                        discard;

    wr_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              bus_owned_q;
    logic              drive_q;
    logic              ce_n_q;
    logic              we_n_q;
    logic              ub_n_q;
    logic              lb_n_q;

    assign push_req = '{addr: wr_addr, data: wr_data, be: wr_be};

    sync_fifo #(
        .ENTRY_T (req_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (Clk),
        .rst_ni      (Reset),
        .push_i      (wr_valid),
        .push_data_i (push_req),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Head decisions are only made between bus cycles (IDLE or HOLD).
    // A be==0 head seen in HOLD is left queued; IDLE discards it next cycle.
    always_comb begin
        launch  = 1'b0;
        discard = 1'b0;
        if (!fifo_empty && !rd_active) begin
            case (state_q)
                IDLE: begin
                    if (head.be == 2'b00) discard = 1'b1;
                    else                  launch  = 1'b1;
                end
                HOLD:    launch = (head.be != 2'b00);
                default: ;
            endcase
        end
    end

    assign fifo_pop = launch | discard;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            bus_owned_q <= 1'b0;
            drive_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (launch) begin
                        state_q     <= SETUP;
                        addr_q      <= head.addr;
                        data_q      <= head.data;
                        ub_n_q      <= ~head.be[1];
                        lb_n_q      <= ~head.be[0];
                        bus_owned_q <= 1'b1;
                        drive_q     <= 1'b1;
                        ce_n_q      <= 1'b0;
                        we_n_q      <= 1'b1;
                    end else if (state_q == HOLD) begin
                        // Release the bus; address/data keep their last value.
                        state_q     <= IDLE;
                        bus_owned_q <= 1'b0;
                        drive_q     <= 1'b0;
                        ce_n_q      <= 1'b1;
                        ub_n_q      <= 1'b1;
                        lb_n_q      <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q <= PULSE;
                    we_n_q  <= 1'b0;
                    cnt_q   <= CNT_W'(WE_CYCLES - 1);
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= HOLD;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ready     = !fifo_full;
    assign fifo_count   = fifo_cnt;
    assign idle         = fifo_empty && (state_q == IDLE);
    assign bus_owned    = bus_owned_q;
    assign SRAM_ADDR    = addr_q;
    assign Data_to_SRAM = data_q;
    assign data_drive   = drive_q;
    assign CE_N         = ce_n_q;
    assign WE_N         = we_n_q;
    assign UB_N         = ub_n_q;
    assign LB_N         = lb_n_q;

endmodule

// File: doc/sram_write_ctrl.md
Name: sram_write_ctrl

Overview:
- Write-side counterpart of the SRAM read path: accepts CPU/game-logic write requests, buffers them, and generates timed asynchronous-SRAM write cycles (CE_N/WE_N/UB_N/LB_N, address, driven data).
- Sits between the game/CPU logic and the top-level SRAM pins.
- Yields the bus to the read path whenever a read is pending.
- Top level muxes its pin outputs with the read path's using bus_owned.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- FIFO_DEPTH, 8, request buffer entries; power of two, minimum 2
- WE_CYCLES, 2, WE_N low pulse width in clocks; minimum 1

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  request accepted when wr_valid & wr_ready at rising Clk
- wr_addr  in  ADDR_W  word address
- wr_data  in  DATA_W  write data
- wr_be  in  2  byte enables; [1]=upper, [0]=lower
- rd_active  in  1  read path requests/holds the SRAM bus
- bus_owned  out  1  controller drives SRAM pins this cycle
- SRAM_ADDR  out  ADDR_W  address to SRAM
- Data_to_SRAM  out  DATA_W  data to tristate buffer
- data_drive  out  1  tristate enable for Data_to_SRAM
- CE_N  out  1  chip enable, active-low
- WE_N  out  1  write enable, active-low
- UB_N  out  1  upper byte enable, active-low
- LB_N  out  1  lower byte enable, active-low
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries
- idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (Reset==0 at rising Clk) forces the following on the next cycle:
  - FSM to IDLE; FIFO flushed; fifo_count=0; wr_ready=1; idle=1.
  - bus_owned=0, data_drive=0; CE_N=WE_N=UB_N=LB_N=1; SRAM_ADDR=0; Data_to_SRAM=0.
- Reset during PULSE: WE_N returns high on that edge. The in-flight word is undefined in SRAM; this is accepted behaviour.
- All pin-side outputs are registered. No combinational path from inputs to SRAM pins.
- FIFO:
  - wr_ready = !full, computed from registered state only.
  - No bypass: a push into an empty FIFO is visible to the FSM the next cycle.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pushes while full are ignored (wr_ready=0).
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - If FIFO non-empty and rd_active==0, pop the head.
  - If head wr_be==2'b00, discard it (no bus cycle) and stay in IDLE. This costs one cycle per entry.
  - Otherwise latch addr/data/be and go to SETUP.
  - If rd_active==1, stay in IDLE with bus_owned=0.
- SETUP (1 cycle):
  - bus_owned=1, CE_N=0, WE_N=1, data_drive=1.
  - UB_N=~be[1], LB_N=~be[0]; SRAM_ADDR and Data_to_SRAM hold the latched values.
- PULSE (WE_CYCLES cycles): as SETUP but WE_N=0. A counter tracks the pulse length.
- HOLD (1 cycle):
  - WE_N=1; CE_N, address and data held; data_drive=1.
  - Next state: SETUP directly (pop next entry) if FIFO non-empty, head be!=0, and rd_active==0. Otherwise IDLE.
  - A be==0 head returns to IDLE, where it is discarded.
- rd_active is sampled only in IDLE and HOLD. An in-progress cycle always completes; it is never aborted by a read.
- Throughput: 2+WE_CYCLES clocks per write (4 with defaults). Back-to-back writes have no IDLE gap.
- Latency: wr_valid accept edge to WE_N falling = 3 clocks with an empty FIFO (push, pop→SETUP, PULSE).
- On leaving HOLD to IDLE: bus_owned=0, data_drive=0, CE_N=1, UB_N=LB_N=1.

Decomposition:
- Shared package sram_pkg holds:
  - constants SRAM_ADDR_W=20, SRAM_DATA_W=16
  - typedef sram_wr_req_t {addr, data, be}
  - enum wr_state_t {IDLE, SETUP, PULSE, HOLD}
- One sub-module: sync_fifo.
  - Parameterised by width and depth; stores sram_wr_req_t.
  - Provides count/full/empty; same synchronous active-low reset.

Test Plan:
- Reset low 2 cycles, then high → all outputs at reset values, wr_ready=1, idle=1.
- Single write addr=20'h0_1234, data=16'hBEEF, be=2'b11 → WE_N low exactly cycles 3–4 after accept edge. SRAM_ADDR=0x01234 and Data_to_SRAM=0xBEEF stable from SETUP through HOLD. CE_N=0 for 4 cycles; then idle=1.
- Push 10 writes back-to-back with FIFO_DEPTH=8 → wr_ready drops at count=8. All 10 appear on the pins in order at one write per 4 clocks. Behavioural SRAM model contents match.
- rd_active=1 held while 3 entries queued → bus_owned stays 0 and no CE_N activity. Deassert → writes start within 1 cycle.
- Raise rd_active mid-PULSE → current write finishes through HOLD, then returns to IDLE.
- be=2'b10 → UB_N=0, LB_N=1, and only the upper byte changes in the model. be=2'b00 → entry popped, no CE_N/WE_N activity, fifo_count decrements.
- Assert Reset during PULSE with 5 entries queued → next edge WE_N=1, CE_N=1, fifo_count=0. No further bus cycles occur after release.
